// File: rtl/ro_bank_scheduler_pkg.sv
// Shared types and defaults for the ring-oscillator bank scheduler.
// The heater option is selected by RO_SCHED_HEATER_EN in the top-level file.
package ro_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    REPORT
  } ro_state_e;

  localparam int unsigned N_RO_DEF          = 145;
  localparam int unsigned IDX_W_DEF         = 8;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned GATE_CYCLES_DEF   = 1024;

  // Widest bank supported; callers size-cast the result down to N_RO.
  localparam int unsigned ONEHOT_W = 1024;

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/ro_bank_scheduler_if.sv
// Host-side control and result bus of the ring-oscillator bank scheduler.
interface ro_bank_scheduler_if #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 16
);

  logic             start;
  logic             abort;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] end_idx;
  logic             busy;
  logic             done;
  logic             err;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (
    output start, abort, start_idx, end_idx,
    input  busy, done, err, res_valid, res_idx, res_count, res_ovf
  );

  modport slave (
    input  start, abort, start_idx, end_idx,
    output busy, done, err, res_valid, res_idx, res_count, res_ovf
  );

endinterface

// File: rtl/ro_bank_scheduler_edge_counter.sv
// Synchronises the selected oscillator output and counts its rising edges,
// saturating at the top of the counter range.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             async_in,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             rise;

  // sync_q[1:0] form the synchroniser; sync_q[2] is the edge-detect history.
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      if (clr) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (cnt_en && rise) begin
        if (count_q == '1) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/ro_bank_scheduler.sv
// Sweeps the ring-oscillator bank one instance at a time and reports an edge
// count per oscillator. Define RO_SCHED_HEATER_EN to add the bank-heater input.
module ro_bank_scheduler
  import ro_sched_pkg::*;
#(
  parameter int unsigned N_RO          = N_RO_DEF,
  parameter int unsigned IDX_W         = IDX_W_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ro_bank_scheduler_if.slave host,
`ifdef RO_SCHED_HEATER_EN
  input  logic              heater,
`endif
  input  logic              ro_in,
  output logic [N_RO-1:0]   ro_en,
  output logic [IDX_W-1:0]  ro_sel
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);

  ro_state_e        state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [IDX_W-1:0] ro_sel_q;
  logic [IDX_W-1:0] end_q;
  logic [N_RO-1:0]  ro_en_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             rv_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             heater_on;
  logic             range_ok;
  logic             last;
  logic [IDX_W-1:0] sel_next;

`ifdef RO_SCHED_HEATER_EN
  assign heater_on = heater;
`else
  assign heater_on = 1'b0;
`endif

  assign range_ok = (host.start_idx <= host.end_idx) && (32'(host.end_idx) < N_RO);
  assign last     = (ro_sel_q == end_q);
  assign sel_next = ro_sel_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      ro_sel_q  <= '0;
      end_q     <= '0;
      ro_en_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
      res_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rv_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ro_en_q <= heater_on ? '1 : '0;
          // abort in the same cycle suppresses start, including its err pulse
          if (host.start && !host.abort && !heater_on) begin
            if (range_ok) begin
              state_q  <= SETTLE;
              tmr_q    <= SETTLE_LD;
              ro_sel_q <= host.start_idx;
              end_q    <= host.end_idx;
              ro_en_q  <= N_RO'(onehot(32'(host.start_idx)));
              busy_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (host.abort) begin
            state_q <= IDLE;
            ro_en_q <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_q == '0) begin
            state_q <= GATE;
            tmr_q   <= GATE_LD;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        GATE: begin
          if (host.abort) begin
            state_q <= IDLE;
            ro_en_q <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_q == '0) begin
            // Result strobe and done are set on REPORT entry so they line up
            // with the REPORT cycle and the final count.
            state_q   <= REPORT;
            ro_en_q   <= '0;
            rv_q      <= 1'b1;
            res_idx_q <= ro_sel_q;
            if (last) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        REPORT: begin
          if (host.abort || last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= SETTLE;
            tmr_q    <= SETTLE_LD;
            ro_sel_q <= sel_next;
            ro_en_q  <= N_RO'(onehot(32'(sel_next)));
          end
        end
        default: begin
          state_q <= IDLE;
          ro_en_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == SETTLE),
    .cnt_en   (state_q == GATE),
    .async_in (ro_in),
    .count    (host.res_count),
    .ovf      (host.res_ovf)
  );

  assign ro_en          = ro_en_q;
  assign ro_sel         = ro_sel_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.err       = err_q;
  assign host.res_valid = rv_q;
  assign host.res_idx   = res_idx_q;

endmodule

// File: tb/tb_ro_bank_scheduler.sv
// Directed bench for ro_bank_scheduler: default instance plus a narrow-counter
// instance for saturation.
module tb_ro_bank_scheduler;

  localparam int unsigned N_RO = 145;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ro_bank_scheduler_if #(.IDX_W(8), .CNT_W(16)) h ();
  ro_bank_scheduler_if #(.IDX_W(8), .CNT_W(4))  h2 ();

  logic            ro_in  = 1'b0;
  logic            ro_in2 = 1'b0;
  logic [N_RO-1:0] ro_en, ro_en2;
  logic [7:0]      ro_sel, ro_sel2;

  ro_bank_scheduler #(
    .N_RO(N_RO), .IDX_W(8), .CNT_W(16), .SETTLE_CYCLES(16), .GATE_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .host(h), .ro_in(ro_in), .ro_en(ro_en), .ro_sel(ro_sel)
  );

  ro_bank_scheduler #(
    .N_RO(N_RO), .IDX_W(8), .CNT_W(4), .SETTLE_CYCLES(16), .GATE_CYCLES(64)
  ) dut_sat (
    .clk(clk), .rst(rst), .host(h2), .ro_in(ro_in2), .ro_en(ro_en2), .ro_sel(ro_sel2)
  );

  // Oscillator stand-ins: period = 2*half clk cycles, 0 holds low.
  int half1 = 0, half2 = 0, ph1 = 0, ph2 = 0;
  always @(negedge clk) begin
    if (half1 == 0) begin ph1 = 0; ro_in = 1'b0; end
    else begin ph1++; if (ph1 >= half1) begin ph1 = 0; ro_in = ~ro_in; end end
    if (half2 == 0) begin ph2 = 0; ro_in2 = 1'b0; end
    else begin ph2++; if (ph2 >= half2) begin ph2 = 0; ro_in2 = ~ro_in2; end end
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [7:0] s, input logic [7:0] e);
    h.start_idx = s;
    h.end_idx   = e;
    h.start     = 1'b1;
    tick();
    h.start     = 1'b0;
  endtask

  function automatic logic [N_RO-1:0] oh(input int unsigned i);
    logic [N_RO-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  int cyc, nres, ndone, bad, last_cyc, cnt;

  initial begin
    h.start = 0; h.abort = 0; h.start_idx = '0; h.end_idx = '0;
    h2.start = 0; h2.abort = 0; h2.start_idx = '0; h2.end_idx = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_ro_en", 160'(ro_en), 160'(0));
    chk("rst_ro_sel", 160'(ro_sel), 160'(0));
    chk("rst_flags", 160'({h.busy, h.done, h.err, h.res_valid, h.res_ovf}), 160'(0));
    chk("rst_res", 160'({h.res_idx, h.res_count}), 160'(0));
    rst = 1'b0;
    tick();

    // Reset in the middle of GATE
    start1(8'd7, 8'd7);
    repeat (30) tick();
    chk("gate7_ro_en", 160'(ro_en), 160'(oh(7)));
    chk("gate7_busy", 160'(h.busy), 160'(1));
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ro_en", 160'(ro_en), 160'(0));
    chk("async_rst_state", 160'({h.busy, h.res_valid, ro_sel}), 160'(0));
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single oscillator, clk/8
    half1 = 4;
    start1(8'd5, 8'd5);
    cyc = 1;
    chk("single_sel", 160'(ro_sel), 160'(5));
    chk("single_en_settle", 160'(ro_en), 160'(oh(5)));
    while (!h.res_valid && cyc < 1200) begin
      tick();
      cyc++;
      if (cyc == 500) chk("single_en_gate", 160'(ro_en), 160'(oh(5)));
    end
    chk("single_latency", 160'(cyc), 160'(1041));
    chk("single_idx", 160'(h.res_idx), 160'(5));
    cnt = int'(h.res_count);
    chk("single_count_128pm1", 160'(cnt >= 127 && cnt <= 129), 160'(1));
    chk("single_done_busy", 160'({h.done, h.busy}), 160'(2'b10));
    chk("single_report_en", 160'(ro_en), 160'(0));
    tick();
    chk("single_after", 160'({h.done, h.res_valid}), 160'(0));

    // Sweep 0..3, oscillator idle
    half1 = 0;
    start1(8'd0, 8'd3);
    cyc = 1; nres = 0; ndone = 0; bad = 0; last_cyc = 0;
    while (nres < 4 && cyc < 5000) begin
      ndone += int'(h.done);
      if (h.res_valid) begin
        chk("sweep_idx", 160'(h.res_idx), 160'(nres));
        chk("sweep_report_en", 160'(ro_en), 160'(0));
        chk("sweep_count", 160'(h.res_count), 160'(0));
        chk("sweep_spacing", 160'(cyc - last_cyc), 160'(1041));
        last_cyc = cyc;
        nres++;
      end else if (h.busy && !$onehot(ro_en)) begin
        bad++;
      end
      if (nres < 4) begin tick(); cyc++; end
    end
    chk("sweep_nres", 160'(nres), 160'(4));
    chk("sweep_done_cnt", 160'(ndone), 160'(1));
    chk("sweep_onehot", 160'(bad), 160'(0));
    chk("sweep_end_busy", 160'(h.busy), 160'(0));
    tick();

    // Invalid ranges
    start1(8'd10, 8'd9);
    chk("inv1_err", 160'(h.err), 160'(1));
    chk("inv1_busy_en", 160'({h.busy, ro_en}), 160'(0));
    tick();
    chk("inv1_err_pulse", 160'(h.err), 160'(0));
    start1(8'd10, 8'd145);
    chk("inv2_err", 160'(h.err), 160'(1));
    chk("inv2_busy_en", 160'({h.busy, ro_en}), 160'(0));
    tick();

    // Abort during GATE of index 2
    start1(8'd0, 8'd3);
    nres = 0; cyc = 0;
    while (nres < 2 && cyc < 3000) begin
      if (h.res_valid) nres++;
      tick();
      cyc++;
    end
    repeat (100) tick();
    chk("abort_pre_sel", 160'(ro_sel), 160'(2));
    h.abort = 1'b1;
    tick();
    h.abort = 1'b0;
    chk("abort_idle", 160'({h.busy, ro_en}), 160'(0));
    nres = 0; ndone = 0;
    repeat (1200) begin
      nres  += int'(h.res_valid);
      ndone += int'(h.done);
      tick();
    end
    chk("abort_no_res", 160'(nres), 160'(0));
    chk("abort_no_done", 160'(ndone), 160'(0));

    // start and abort together in IDLE
    h.start_idx = 8'd0; h.end_idx = 8'd0;
    h.start = 1'b1; h.abort = 1'b1;
    tick();
    h.start = 1'b0; h.abort = 1'b0;
    chk("start_abort", 160'({h.busy, h.err, ro_en}), 160'(0));
    repeat (3) tick();
    chk("start_abort_later", 160'({h.busy, ro_en}), 160'(0));

    // Saturation: CNT_W=4, GATE=64, clk/4
    half2 = 2;
    h2.start_idx = 8'd0; h2.end_idx = 8'd0;
    h2.start = 1'b1;
    tick();
    h2.start = 1'b0;
    cyc = 1;
    while (!h2.res_valid && cyc < 200) begin tick(); cyc++; end
    chk("sat_latency", 160'(cyc), 160'(81));
    chk("sat_count", 160'(h2.res_count), 160'(15));
    chk("sat_ovf", 160'(h2.res_ovf), 160'(1));
    chk("sat_done", 160'(h2.done), 160'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
